// File: rtl/pdu_pkg.sv
// Shared encodings for the debug controller: host opcodes, FSM states,
// response codes and the disabled-breakpoint value.
package pdu_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_RUN     = 3'd1,
    OP_STEP    = 3'd2,
    OP_SET_BP  = 3'd3,
    OP_CLR_BP  = 3'd4,
    OP_STATUS  = 3'd5,
    OP_HALT    = 3'd6,
    OP_ILLEGAL = 3'd7
  } pdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXEC      = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STOP_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } pdu_state_e;

  localparam logic [31:0] BP_NONE_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] RSP_OK          = 32'h0000_0000;
  localparam logic [31:0] RSP_RUN_ISSUED  = 32'h0000_0001;
  localparam logic [31:0] RSP_ILLEGAL     = 32'hDEAD_BEEF;
  localparam logic [31:0] RSP_NOT_STOPPED = 32'hFFFF_FFFD;
  localparam logic [31:0] RSP_TIMEOUT     = 32'hFFFF_FFFE;

  // Status word: stopped flag in the MSB, low 31 bits of the ID-stage PC.
  function automatic logic [31:0] status_word(input logic stop, input logic [30:0] pc);
    return {stop, pc};
  endfunction

endpackage

// File: rtl/pdu_debug_ctrl_if.sv
// Host command/response channels of the debug controller.
// Both channels are valid/ready: a transfer happens on a clk edge where valid
// and ready are both 1; the sender holds valid and payload stable until then.
interface pdu_debug_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pdu_edge_detect.sv
// Rising-edge detector for a slow signal sampled as data (the gated CPU clock).
module pdu_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/pdu_debug_ctrl.sv
// Processor debug unit controller: executes host commands and drives the
// run/halt pulses and breakpoint register toward the processor control unit.
module pdu_debug_ctrl
  import pdu_pkg::*;
#(
  parameter logic [31:0] BP_NONE      = BP_NONE_DEFAULT,
  parameter int          STEP_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  pdu_debug_ctrl_if.slave    host,
  input  logic               cpu_stop,
  input  logic               cpu_clk,
  input  logic [31:0]        id_pc,
  output logic               pdu_run,
  output logic [31:0]        pdu_breakpoint,
  output logic               pdu_halt,
  output pdu_state_e         fsm_state
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(STEP_TIMEOUT - 1);

  pdu_state_e  state;
  pdu_op_e     op_q;
  logic [15:0] timeout;
  logic        stop_q;
  logic        clk_rise;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;

  pdu_edge_detect u_clk_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (cpu_clk),
    .rise (clk_rise)
  );

  assign host.cmd_ready = (state == ST_IDLE) && !rst;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign fsm_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      op_q           <= OP_NOP;
      timeout        <= '0;
      stop_q         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      pdu_run        <= 1'b0;
      pdu_halt       <= 1'b0;
      pdu_breakpoint <= BP_NONE;
    end else begin
      pdu_run  <= 1'b0;
      pdu_halt <= 1'b0;
      stop_q   <= cpu_stop;
      case (state)
        ST_IDLE: begin
          // Pulses are decided at acceptance so they are visible during EXEC.
          if (host.cmd_valid) begin
            op_q  <= pdu_op_e'(host.cmd_op);
            state <= ST_EXEC;
            case (pdu_op_e'(host.cmd_op))
              OP_SET_BP: pdu_breakpoint <= host.cmd_data;
              OP_CLR_BP: pdu_breakpoint <= BP_NONE;
              OP_RUN,
              OP_STEP:   pdu_run <= cpu_stop;
              OP_HALT:   pdu_halt <= 1'b1;
              default:   ;
            endcase
          end
        end
        ST_EXEC: begin
          timeout     <= '0;
          state       <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= RSP_OK;
          case (op_q)
            OP_RUN:     rsp_data_q <= pdu_run ? RSP_RUN_ISSUED : RSP_OK;
            OP_STEP: begin
              if (pdu_run) begin
                state       <= ST_STEP_WAIT;
                rsp_valid_q <= 1'b0;
              end else begin
                rsp_data_q  <= RSP_NOT_STOPPED;
              end
            end
            OP_STATUS:  rsp_data_q <= status_word(cpu_stop, id_pc[30:0]);
            OP_HALT: begin
              state       <= ST_STOP_WAIT;
              rsp_valid_q <= 1'b0;
            end
            OP_ILLEGAL: rsp_data_q <= RSP_ILLEGAL;
            default:    ;
          endcase
        end
        ST_STEP_WAIT: begin
          timeout <= timeout + 16'd1;
          if (timeout == TIMEOUT_LAST) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= RSP_TIMEOUT;
          end else if (cpu_stop && !stop_q) begin
            // CPU stopped on its own (breakpoint/interrupt): no halt needed.
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= id_pc;
          end else if (clk_rise) begin
            pdu_halt <= 1'b1;
            state    <= ST_STOP_WAIT;
          end
        end
        ST_STOP_WAIT: begin
          timeout <= timeout + 16'd1;
          if (timeout == TIMEOUT_LAST) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= RSP_TIMEOUT;
          end else if (cpu_stop) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= id_pc;
          end
        end
        ST_RESP: begin
          if (host.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
